// File: rtl/s_mem_arbiter.sv
// Round-robin, lock-on-hold arbiter sharing the single-port RC4 S-memory among the phase FSMs.
// Grant one edge after req; read reply RD_LAT cycles after the address; non-owners simply wait on req.
module s_mem_arbiter #(
    parameter int N_REQ  = 3,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*ADDR_W-1:0] req_address,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic [N_REQ-1:0]        req_wren,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        rd_valid,
    output logic [DATA_W-1:0]       rd_data,
    output logic [ADDR_W-1:0]       mem_address,
    output logic [DATA_W-1:0]       mem_data,
    output logic                    mem_wren,
    input  logic [DATA_W-1:0]       mem_q,
    output logic                    busy,
    output logic                    proto_err
);
    localparam int OW_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic {ST_IDLE, ST_OWN} state_t;

    state_t            r_state;
    logic [OW_W-1:0]   r_owner;
    logic [OW_W-1:0]   r_last_owner;
    logic [N_REQ-1:0]  r_gnt;
    logic              r_proto_err;
    logic [RD_LAT-1:0] r_pipe_vld;
    logic [OW_W-1:0]   r_pipe_tag [RD_LAT];

    logic              w_found;
    logic [OW_W-1:0]   w_winner;
    logic [OW_W-1:0]   w_idx;
    logic              w_own_req;
    logic              w_rd_issue;
    logic [ADDR_W-1:0] w_own_addr;
    logic [DATA_W-1:0] w_own_data;

    // Search starts just after the previous owner so every requester gets a turn.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_idx = OW_W'((int'(r_last_owner) + k) % N_REQ);
            if (!w_found && req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    assign w_own_addr = req_address[int'(r_owner) * ADDR_W +: ADDR_W];
    assign w_own_data = req_data[int'(r_owner) * DATA_W +: DATA_W];
    assign w_own_req  = (r_state == ST_OWN) && req[r_owner];
    assign w_rd_issue = w_own_req && !req_wren[r_owner];

    assign mem_wren    = w_own_req && req_wren[r_owner];
    assign mem_address = (r_state == ST_OWN) ? w_own_addr : '0;
    assign mem_data    = (r_state == ST_OWN) ? w_own_data : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_owner      <= '0;
            r_last_owner <= OW_W'(N_REQ - 1);
            r_gnt        <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_gnt        <= N_REQ'(1) << w_winner;
                        r_owner      <= w_winner;
                        r_last_owner <= w_winner;
                        r_state      <= ST_OWN;
                    end
                end
                ST_OWN: begin
                    if (!req[r_owner]) begin
                        r_gnt   <= '0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_gnt   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // A write attempted without the grant never reaches the RAM but is remembered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_proto_err <= 1'b0;
        end else if (|(req_wren & ~r_gnt)) begin
            r_proto_err <= 1'b1;
        end
    end

    // Tags follow each read through the RAM latency so replies reach the issuer after handover.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipe_vld <= '0;
            for (int s = 0; s < RD_LAT; s++) begin
                r_pipe_tag[s] <= '0;
            end
        end else begin
            r_pipe_vld[0] <= w_rd_issue;
            r_pipe_tag[0] <= r_owner;
            for (int s = 1; s < RD_LAT; s++) begin
                r_pipe_vld[s] <= r_pipe_vld[s-1];
                r_pipe_tag[s] <= r_pipe_tag[s-1];
            end
        end
    end

    always_comb begin
        rd_valid = '0;
        rd_data  = '0;
        if (r_pipe_vld[RD_LAT-1]) begin
            rd_valid[r_pipe_tag[RD_LAT-1]] = 1'b1;
            rd_data                        = mem_q;
        end
    end

    assign gnt       = r_gnt;
    assign busy      = |r_gnt;
    assign proto_err = r_proto_err;

endmodule

// File: tb/tb_s_mem_arbiter.sv
// Bench for s_mem_arbiter: directed scenarios plus random traffic against a queue-based reference model.
`timescale 1ns/1ps
module tb_s_mem_arbiter;
    localparam int N_REQ  = 3;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int RD_LAT = 2;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [N_REQ-1:0]        req;
    logic [N_REQ-1:0]        req_wren;
    logic [N_REQ*ADDR_W-1:0] req_address;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        rd_valid;
    logic [DATA_W-1:0]       rd_data;
    logic [ADDR_W-1:0]       mem_address;
    logic [DATA_W-1:0]       mem_data;
    logic                    mem_wren;
    logic [DATA_W-1:0]       mem_q;
    logic                    busy;
    logic                    proto_err;

    logic [7:0] t_addr [N_REQ];
    logic [7:0] t_data [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_pack
        assign req_address[g*ADDR_W +: ADDR_W] = t_addr[g];
        assign req_data[g*DATA_W +: DATA_W]    = t_data[g];
    end

    always #5 clk = ~clk;

    s_mem_arbiter #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_address(req_address), .req_data(req_data),
        .req_wren(req_wren), .gnt(gnt), .rd_valid(rd_valid), .rd_data(rd_data),
        .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q),
        .busy(busy), .proto_err(proto_err)
    );

    // S-memory stand-in: identity contents, two-cycle registered read.
    logic [7:0] ram [256];
    logic [7:0] ram_a1;
    bit         ram_ready;
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'(i);
            ram_ready <= 1'b1;
        end else if (mem_wren) begin
            ram[mem_address] <= mem_data;
        end
        ram_a1 <= mem_address;
        mem_q  <= ram[ram_a1];
    end

    // Reference model: who owns the port, shadow memory, and queue of replies due.
    typedef struct {
        int         due;
        int         tag;
        logic [7:0] dat;
    } rep_t;

    bit         m_busy;
    int         m_owner;
    int         m_last;
    bit         m_err;
    logic [7:0] shadow [256];
    rep_t       m_q [$];
    int         cyc;
    int         n_tests;
    int         n_fail;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_last  = N_REQ - 1;
        m_err   = 1'b0;
        m_q.delete();
    endtask

    task automatic model_edge();
        rep_t r;
        if (!rst_n) begin
            model_reset();
        end else begin
            if (m_q.size() > 0 && m_q[0].due == cyc) void'(m_q.pop_front());
            for (int i = 0; i < N_REQ; i++)
                if (req_wren[i] && !(m_busy && m_owner == i)) m_err = 1'b1;
            if (m_busy) begin
                if (req[m_owner]) begin
                    if (req_wren[m_owner]) begin
                        shadow[t_addr[m_owner]] = t_data[m_owner];
                    end else begin
                        r.due = cyc + RD_LAT;
                        r.tag = m_owner;
                        r.dat = shadow[t_addr[m_owner]];
                        m_q.push_back(r);
                    end
                end else begin
                    m_busy = 1'b0;
                end
            end else begin
                for (int k = 1; k <= N_REQ; k++) begin
                    if (!m_busy && req[(m_last + k) % N_REQ]) begin
                        m_busy  = 1'b1;
                        m_owner = (m_last + k) % N_REQ;
                        m_last  = m_owner;
                    end
                end
            end
        end
        cyc++;
    endtask

    task automatic check_cycle();
        logic [N_REQ-1:0] e_gnt, e_rv;
        logic [7:0]       e_addr, e_data, e_rd;
        logic             e_wren;
        e_gnt  = m_busy ? N_REQ'(1 << m_owner) : '0;
        e_addr = m_busy ? t_addr[m_owner] : 8'h00;
        e_data = m_busy ? t_data[m_owner] : 8'h00;
        e_wren = m_busy && req[m_owner] && req_wren[m_owner];
        e_rv   = '0;
        e_rd   = 8'h00;
        if (m_q.size() > 0 && m_q[0].due == cyc) begin
            e_rv = N_REQ'(1 << m_q[0].tag);
            e_rd = m_q[0].dat;
        end
        chk("gnt", 64'(gnt), 64'(e_gnt));
        chk("busy", 64'(busy), 64'(m_busy));
        chk("mem_wren", 64'(mem_wren), 64'(e_wren));
        chk("mem_address", 64'(mem_address), 64'(e_addr));
        chk("mem_data", 64'(mem_data), 64'(e_data));
        chk("rd_valid", 64'(rd_valid), 64'(e_rv));
        chk("rd_data", 64'(rd_data), 64'(e_rd));
        chk("proto_err", 64'(proto_err), 64'(m_err));
    endtask

    task automatic step();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_idle();
        req      = '0;
        req_wren = '0;
        for (int i = 0; i < N_REQ; i++) begin
            t_addr[i] = 8'h00;
            t_data[i] = 8'h00;
        end
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        model_reset();
        repeat (n) step();
        rst_n = 1'b1;
    endtask

    task automatic wait_grant(input string nm, input logic [N_REQ-1:0] exp);
        int n = 0;
        while (gnt == '0 && n < 10) begin
            step();
            n++;
        end
        chk(nm, 64'(gnt), 64'(exp));
    endtask

    task automatic own1(input logic [7:0] a, input logic w, input logic [7:0] d);
        t_addr[1]   = a;
        req_wren[1] = w;
        t_data[1]   = d;
        step();
    endtask

    function automatic int oh2idx(input logic [N_REQ-1:0] v);
        case (v)
            3'b001:  return 0;
            3'b010:  return 1;
            3'b100:  return 2;
            default: return 9;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int         order [4];
        int         n_idle;
        logic [7:0] s3, s7, n3, n7;
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        for (int i = 0; i < 256; i++) shadow[i] = 8'(i);
        set_idle();

        // 1: random inputs under reset leave every output at zero; first grant latency
        rst_n = 1'b0;
        model_reset();
        for (int n = 0; n < 6; n++) begin
            req      = N_REQ'($urandom);
            req_wren = N_REQ'($urandom);
            for (int i = 0; i < N_REQ; i++) begin
                t_addr[i] = 8'($urandom);
                t_data[i] = 8'($urandom);
            end
            step();
            chk("rst_ctrl_zero", 64'({gnt, rd_valid, mem_wren, busy, proto_err}), 64'h0);
            chk("rst_bus_zero", 64'({rd_data, mem_address, mem_data}), 64'h0);
        end
        set_idle();
        rst_n = 1'b1;
        step();
        req = 3'b010;
        chk("t1_gnt_before_edge", 64'(gnt), 64'h0);
        step();
        chk("t1_gnt_after_edge", 64'(gnt), 64'b010);
        chk("t1_busy", 64'(busy), 64'h1);

        // 2: round-robin order with a single idle cycle between owners
        set_idle();
        do_reset(2);
        req = 3'b111;
        for (int g = 0; g < 4; g++) begin
            n_idle = 0;
            while (gnt == '0 && n_idle < 10) begin
                step();
                n_idle++;
            end
            order[g] = oh2idx(gnt);
            if (g > 0) chk("t2_idle_gap", 64'(n_idle), 64'd1);
            if (g < 3) begin
                repeat (3) step();
                req = 3'b111 & ~gnt;
                step();
                req = 3'b111;
            end
        end
        chk("t2_order0", 64'(order[0]), 64'd0);
        chk("t2_order1", 64'(order[1]), 64'd1);
        chk("t2_order2", 64'(order[2]), 64'd2);
        chk("t2_order3", 64'(order[3]), 64'd0);
        set_idle();
        repeat (4) step();

        // 3: tagged read reply after exactly RD_LAT cycles
        req = 3'b010;
        wait_grant("t3_gnt", 3'b010);
        t_addr[1] = 8'h05;
        step();
        t_addr[1] = 8'h20;
        chk("t3_no_early_reply", 64'(rd_valid), 64'h0);
        step();
        chk("t3_rd_valid", 64'(rd_valid), 64'b010);
        chk("t3_rd_data", 64'(rd_data), 64'h05);
        set_idle();
        repeat (4) step();

        // 4: reply drains to the issuer after it hands the port to requester 2
        req = 3'b001;
        wait_grant("t4_gnt0", 3'b001);
        t_addr[0] = 8'h11;
        req = 3'b101;
        step();
        req = 3'b100;
        step();
        chk("t4_reply_to_0", 64'(rd_valid), 64'b001);
        chk("t4_reply_data", 64'(rd_data), 64'h11);
        step();
        chk("t4_gnt2", 64'(gnt), 64'b100);
        chk("t4_no_dup_reply", 64'(rd_valid), 64'h0);
        set_idle();
        repeat (4) step();

        // 5: write without grant is blocked and flagged until reset
        req = 3'b001;
        wait_grant("t5_gnt0", 3'b001);
        req       = 3'b101;
        req_wren  = 3'b100;
        t_addr[2] = 8'hFF;
        t_data[2] = 8'hAA;
        #1;
        chk("t5_mem_wren_blocked", 64'(mem_wren), 64'h0);
        step();
        chk("t5_err_set", 64'(proto_err), 64'h1);
        req_wren = '0;
        repeat (3) step();
        chk("t5_err_sticky", 64'(proto_err), 64'h1);
        chk("t5_ram_ff_unchanged", 64'(ram[8'hFF]), 64'hFF);
        set_idle();
        do_reset(2);
        chk("t5_err_cleared", 64'(proto_err), 64'h0);

        // 6: KSA-style swap of S[3] and S[7], then read back
        req = 3'b010;
        wait_grant("t6_gnt1", 3'b010);
        own1(8'd3, 1'b0, 8'h00);
        own1(8'd7, 1'b0, 8'h00);
        s3 = rd_data;
        chk("t6_rd3_valid", 64'(rd_valid), 64'b010);
        own1(8'd0, 1'b0, 8'h00);
        s7 = rd_data;
        own1(8'd3, 1'b1, s7);
        own1(8'd7, 1'b1, s3);
        own1(8'd7, 1'b0, 8'h00);
        own1(8'd3, 1'b0, 8'h00);
        n7 = rd_data;
        own1(8'd0, 1'b0, 8'h00);
        n3 = rd_data;
        chk("t6_old_s3", 64'(s3), 64'h03);
        chk("t6_old_s7", 64'(s7), 64'h07);
        chk("t6_new_s7", 64'(n7), 64'h03);
        chk("t6_new_s3", 64'(n3), 64'h07);
        chk("t6_ram3", 64'(ram[8'd3]), 64'h07);
        chk("t6_ram7", 64'(ram[8'd7]), 64'h03);
        set_idle();
        repeat (3) step();

        // Random traffic, with occasional mid-operation resets
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (m_busy && m_owner == i) begin
                    req[i]      = ($urandom_range(0, 7) != 0);
                    req_wren[i] = ($urandom_range(0, 2) == 0);
                end else begin
                    req[i]      = ($urandom_range(0, 2) == 0);
                    req_wren[i] = ($urandom_range(0, 99) == 0);
                end
                t_addr[i] = 8'($urandom);
                t_data[i] = 8'($urandom);
            end
            if (n % 600 == 599) do_reset(2);
            else step();
        end
        set_idle();
        repeat (4) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
